// File: rtl/dmem_lsu_if.sv
// Request/response and data-memory signal bundle for the load/store unit.
// The slave modport is the LSU side; the master modport is the datapath/memory side.
interface dmem_lsu_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          err_sticky;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_wd;
    logic [31:0]   dm_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, err_sticky, dm_we, dm_addr, dm_wd
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, dm_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_sticky, dm_we, dm_addr, dm_wd
    );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit between the datapath and a word-addressed data memory.
// Loads and word stores take one cycle; byte/half stores do a two-cycle read-modify-write.
module dmem_lsu #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic     clk,
    input  logic     reset,
    dmem_lsu_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_RD = 2'd1,
        RMW_WR = 2'd2
    } state_e;

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic [15:0]   wdata_q;
    logic [DW-1:0] old_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic          err_sticky_q;
    logic [31:0]   rsp_rdata_q;

    logic          accept;
    logic          misaligned;
    logic          word_store;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_d;
    logic [DW-1:0] merge_d;

    assign bus.req_ready = (state_q == IDLE) && reset;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = (bus.req_addr[1:0] != 2'b00);
            2'b11:   misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    assign word_store = accept && bus.req_we && !misaligned && (bus.req_size == 2'b10);

    // Little-endian lane select and extension of the load result
    always_comb begin
        lane_b = bus.dm_rd[7:0];
        case (bus.req_addr[1:0])
            2'd1:    lane_b = bus.dm_rd[15:8];
            2'd2:    lane_b = bus.dm_rd[23:16];
            2'd3:    lane_b = bus.dm_rd[31:24];
            default: lane_b = bus.dm_rd[7:0];
        endcase
        lane_h = bus.req_addr[1] ? bus.dm_rd[31:16] : bus.dm_rd[15:0];
        case (bus.req_size)
            2'b00:   load_d = {{24{bus.req_signed & lane_b[7]}}, lane_b};
            2'b01:   load_d = {{16{bus.req_signed & lane_h[15]}}, lane_h};
            default: load_d = bus.dm_rd;
        endcase
    end

    always_comb begin
        merge_d = old_q;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd1:    merge_d[15:8]  = wdata_q[7:0];
                2'd2:    merge_d[23:16] = wdata_q[7:0];
                2'd3:    merge_d[31:24] = wdata_q[7:0];
                default: merge_d[7:0]   = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_d[31:16] = wdata_q;
        end else begin
            merge_d[15:0] = wdata_q;
        end
    end

    // Memory port: follows the request in IDLE, the latched address during RMW
    always_comb begin
        bus.dm_addr = {bus.req_addr[AW-1:2], 2'b00};
        bus.dm_we   = 1'b0;
        bus.dm_wd   = bus.req_wdata;
        case (state_q)
            RMW_RD: begin
                bus.dm_addr = {addr_q[AW-1:2], 2'b00};
            end
            RMW_WR: begin
                bus.dm_addr = {addr_q[AW-1:2], 2'b00};
                bus.dm_we   = reset;
                bus.dm_wd   = merge_d;
            end
            default: begin
                bus.dm_we = word_store;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= 2'b00;
            wdata_q      <= '0;
            old_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (misaligned) begin
                            rsp_valid_q  <= 1'b1;
                            rsp_err_q    <= 1'b1;
                            rsp_rdata_q  <= '0;
                            err_sticky_q <= 1'b1;
                        end else if (!bus.req_we) begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= load_d;
                        end else if (bus.req_size == 2'b10) begin
                            rsp_valid_q <= 1'b1;
                        end else begin
                            addr_q  <= bus.req_addr;
                            size_q  <= bus.req_size;
                            wdata_q <= bus.req_wdata[15:0];
                            state_q <= RMW_RD;
                        end
                    end
                end
                RMW_RD: begin
                    old_q   <= bus.dm_rd;
                    state_q <= RMW_WR;
                end
                RMW_WR: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomised scoreboard bench for dmem_lsu against a byte-array memory model.
// Expected responses and memory writes are queued at acceptance and checked by a monitor.
module tb_dmem_lsu;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_lsu_if #(.AW(32)) bus();

    dmem_lsu #(.AW(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem [0:63];
    logic [7:0]  refMem [0:255];

    assign bus.dm_rd = mem[bus.dm_addr[7:2]];
    always @(posedge clk) if (bus.dm_we) mem[bus.dm_addr[7:2]] <= bus.dm_wd;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        sticky;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    rsp_t rspQ[$];
    wr_t  wrQ[$];

    int total = 0;
    int bad   = 0;
    logic [31:0] lastRdata   = 32'h0;
    logic        stickyModel = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    function automatic logic [31:0] refWord(input int a);
        return {refMem[a+3], refMem[a+2], refMem[a+1], refMem[a]};
    endfunction

    function automatic bit isErr(input logic [1:0] size, input int a);
        return (size == 2'b11) || (size == 2'b01 && (a % 2) != 0) || (size == 2'b10 && (a % 4) != 0);
    endfunction

    // Drives one request and records what the LSU should eventually do with it
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                 input int a, input logic [31:0] wdata, input bit track);
        int waitCnt;
        int w;
        logic [31:0] val;
        logic [7:0]  b;
        logic [15:0] h;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = 32'(a);
        bus.req_wdata  = wdata;
        waitCnt = 0;
        while (!bus.req_ready && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        if (!bus.req_ready) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            return;
        end
        if (track) begin
            w = a - (a % 4);
            if (isErr(size, a)) begin
                stickyModel = 1'b1;
                lastRdata   = 32'h0;
                rspQ.push_back('{rdata: 32'h0, err: 1'b1, sticky: 1'b1, cyc: cycleCnt + 1});
            end else if (!we) begin
                b = refMem[a];
                h = {refMem[a+1], refMem[a]};
                if (size == 2'b00)      val = {{24{sgn & b[7]}}, b};
                else if (size == 2'b01) val = {{16{sgn & h[15]}}, h};
                else                    val = refWord(a);
                lastRdata = val;
                rspQ.push_back('{rdata: val, err: 1'b0, sticky: stickyModel, cyc: cycleCnt + 1});
            end else begin
                refMem[a] = wdata[7:0];
                if (size != 2'b00) refMem[a+1] = wdata[15:8];
                if (size == 2'b10) begin
                    refMem[a+2] = wdata[23:16];
                    refMem[a+3] = wdata[31:24];
                end
                wrQ.push_back('{addr: 32'(w), data: refWord(w),
                                cyc: (size == 2'b10) ? cycleCnt : cycleCnt + 2});
                rspQ.push_back('{rdata: lastRdata, err: 1'b0, sticky: stickyModel,
                                 cyc: (size == 2'b10) ? cycleCnt + 1 : cycleCnt + 3});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idleCycles(input int n);
        bus.req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every response pulse and every memory write must match the queued expectation
    initial begin
        rsp_t e;
        wr_t  x;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (rspQ.size() == 0) begin
                    checkOutput("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = rspQ.pop_front();
                    checkOutput("rsp_rdata", bus.rsp_rdata, e.rdata);
                    checkOutput("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
                    checkOutput("err_sticky", {31'b0, bus.err_sticky}, {31'b0, e.sticky});
                    checkOutput("rsp_cycle", 32'(cycleCnt), 32'(e.cyc));
                end
            end
            if (bus.dm_we) begin
                if (wrQ.size() == 0) begin
                    checkOutput("dm_we_unexpected", 32'd1, 32'd0);
                end else begin
                    x = wrQ.pop_front();
                    checkOutput("dm_addr", bus.dm_addr, x.addr);
                    checkOutput("dm_wd", bus.dm_wd, x.data);
                    checkOutput("wr_cycle", 32'(cycleCnt), 32'(x.cyc));
                end
            end
        end
    end

    initial begin
        logic [31:0] r;
        logic [1:0]  sz;
        int          a;
        for (int w = 0; w < 64; w++) begin
            r = $urandom;
            mem[w] = r;
            refMem[4*w]   = r[7:0];
            refMem[4*w+1] = r[15:8];
            refMem[4*w+2] = r[23:16];
            refMem[4*w+3] = r[31:24];
        end

        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b10;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h55;
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("reset_dm_we", {31'b0, bus.dm_we}, 32'd0);
            checkOutput("reset_req_ready", {31'b0, bus.req_ready}, 32'd0);
            checkOutput("reset_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
            checkOutput("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
            checkOutput("reset_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
            checkOutput("reset_err_sticky", {31'b0, bus.err_sticky}, 32'd0);
        end
        reset = 1'b1;
        bus.req_valid = 1'b0;
        #1;
        checkOutput("ready_after_reset", {31'b0, bus.req_ready}, 32'd1);

        applyStimulus(1'b1, 2'b10, 1'b0, 'h10, 32'hDEADBEEF, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 'h10, 32'h0, 1'b1);
        applyStimulus(1'b1, 2'b10, 1'b0, 'h20, 32'h11223344, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b0, 'h21, 32'h000000AA, 1'b1);
        checkOutput("ready_in_rmw", {31'b0, bus.req_ready}, 32'd0);
        applyStimulus(1'b0, 2'b00, 1'b1, 'h21, 32'h0, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b0, 'h21, 32'h0, 1'b1);
        applyStimulus(1'b1, 2'b10, 1'b0, 'h30, 32'h00008001, 1'b1);
        applyStimulus(1'b0, 2'b01, 1'b1, 'h30, 32'h0, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0, 'h32, 32'h00001234, 1'b1);
        applyStimulus(1'b0, 2'b10, 1'b0, 'h06, 32'h0, 1'b1);
        applyStimulus(1'b1, 2'b01, 1'b0, 'h05, 32'hFFFF, 1'b1);
        applyStimulus(1'b0, 2'b11, 1'b0, 'h00, 32'h0, 1'b1);
        idleCycles(2);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b10, 1'b0, 4*i, 32'h0, 1'b1);
        idleCycles(2);

        for (int i = 0; i < 300; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom_range(0, 255);
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a = a - (a % 2);
                if (sz == 2'b10) a = a - (a % 4);
            end
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) idleCycles(1);
        end
        idleCycles(5);

        // Abort a read-modify-write while it is reading the old word
        applyStimulus(1'b1, 2'b10, 1'b0, 'h20, 32'h11223344, 1'b1);
        applyStimulus(1'b1, 2'b00, 1'b0, 'h21, 32'h000000AA, 1'b0);
        reset = 1'b0;
        bus.req_valid = 1'b0;
        lastRdata   = 32'h0;
        stickyModel = 1'b0;
        repeat (2) begin
            #1;
            checkOutput("midrmw_dm_we", {31'b0, bus.dm_we}, 32'd0);
            checkOutput("midrmw_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        checkOutput("midrmw_ready", {31'b0, bus.req_ready}, 32'd1);
        checkOutput("midrmw_sticky_clear", {31'b0, bus.err_sticky}, 32'd0);
        idleCycles(3);
        applyStimulus(1'b0, 2'b10, 1'b0, 'h20, 32'h0, 1'b1);
        idleCycles(5);

        checkOutput("rsp_queue_empty", 32'(rspQ.size()), 32'd0);
        checkOutput("wr_queue_empty", 32'(wrQ.size()), 32'd0);
        for (int w = 0; w < 64; w++) checkOutput("mem_final", mem[w], refWord(4*w));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit between the single-cycle datapath and the word-addressed data memory (`dmem`: `we`, `addr`, `wd`, `rd`; combinational read, write on posedge).
- Adds byte and halfword loads (sign- or zero-extended) and byte/halfword stores; sub-word stores use a 2-cycle read-modify-write of the containing word.
- Checks alignment and signals completion through a valid/ready request and a one-cycle response pulse.

Parameters:
- `AW`, 32, address width; `dm_addr` is driven with bits [1:0] forced to 0.
- `DW`, 32, data width; fixed at 32, other values unsupported.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low; 0 = reset.
- `req_valid`  in  1  access request from datapath.
- `req_ready`  out  1  LSU accepts a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_signed`  in  1  loads: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  AW  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle pulse: access complete.
- `rsp_rdata`  out  32  load result, valid with `rsp_valid`.
- `rsp_err`  out  1  misaligned/illegal, valid with `rsp_valid`.
- `err_sticky`  out  1  set on any error; cleared only by reset.
- `dm_we`  out  1  to dmem `we`.
- `dm_addr`  out  AW  to dmem `addr`.
- `dm_wd`  out  32  to dmem `wd`.
- `dm_rd`  in  32  from dmem `rd`.

Behaviour:
- **Lane mapping (little-endian within the word):**
  - byte n = `dm_rd[8n+7:8n]`, n = `addr[1:0]`.
  - half h = `dm_rd[16h+15:16h]`, h = `addr[1]`.
- **Alignment check:** an error is raised for `size=01` with `addr[0]=1`, `size=10` with `addr[1:0]!=0`, or `size=11`. No dmem write occurs for an errored request.
- **FSM states:** IDLE, RMW_RD, RMW_WR.
  - `req_ready` = (state==IDLE) && `reset`.
  - A request is accepted when `req_valid` && `req_ready`.
- **IDLE, load accepted:**
  - `dm_addr` = `req_addr` combinationally, `dm_we`=0.
  - Extended lane is registered into `rsp_rdata`; `rsp_valid`=1 next cycle. Latency 1, state stays IDLE.
- **IDLE, word store accepted:**
  - `dm_we`=1, `dm_wd`=`req_wdata` in the same cycle.
  - `rsp_valid`=1 next cycle; `rsp_rdata` holds its previous value.
- **IDLE, byte/half store accepted:**
  - Latch addr, wdata and size → RMW_RD.
- **RMW_RD:**
  - `dm_addr` = latched address, `dm_we`=0.
  - Capture `dm_rd` into `old_q` → RMW_WR.
- **RMW_WR:**
  - `dm_we`=1; `dm_wd` = `old_q` with the target lane replaced by `wdata[7:0]` or `wdata[15:0]`.
  - → IDLE; `rsp_valid`=1 next cycle. Store latency 3 cycles from acceptance to `rsp_valid`.
- **Errored request:** accepted in IDLE with no dmem write. Next cycle `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0; `err_sticky` set.
- **Output rules:**
  - `rsp_valid` is high for exactly one cycle per accepted request.
  - `rsp_err`=0 on non-error responses.
  - `req_ready`=0 in RMW_RD and RMW_WR; `req_valid` is ignored there and must be held by the datapath.
- **Reset values:** state IDLE; `rsp_valid`, `rsp_rdata`, `rsp_err`, `err_sticky`, `old_q` = 0.
- **Reset outputs:** `dm_we` is forced 0 combinationally while `reset`=0, including during RMW_WR. `req_ready`=0 while `reset`=0.
- **Reset mid-RMW:** the RMW is aborted, no write is issued, and no `rsp_valid` pulse follows.
- **`dm_addr` when idle:** with no request in IDLE, `dm_addr` = `req_addr` and `dm_we`=0.
- **Simultaneous events:** `rsp_valid` from request N may coincide with acceptance of request N+1 in IDLE; back-to-back loads and word stores therefore sustain 1 access per cycle.

Test Plan:
- Reset held 3 cycles with `req_valid`=1, store, word → `dm_we`=0 throughout, `req_ready`=0, all outputs 0; after release `req_ready`=1.
- Word store 0xDEADBEEF @0x10, then word load @0x10 → `dm_we` pulse 1 cycle at addr 0x10; load `rsp_rdata`=0xDEADBEEF one cycle after acceptance, `rsp_err`=0.
- Mem[0x20]=0x11223344:
  - byte store 0xAA @0x21 → `req_ready` low 2 cycles, RMW_WR `dm_wd`=0x1122AA44.
  - then signed byte load @0x21 → 0xFFFFFFAA.
  - unsigned byte load @0x21 → 0x000000AA.
- Mem[0x30]=0x0000_8001: signed half load @0x30 → 0xFFFF8001; half store 0x1234 @0x32 → `dm_wd`=0x12348001.
- Word load @0x06, half store @0x05, `size`=11 @0x00 → each gives `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0, no `dm_we`; `err_sticky`=1 until next reset.
- Back-to-back 4 word loads @0x0,0x4,0x8,0xC with `req_valid` held → 4 consecutive `rsp_valid` cycles with matching data.
- Reset asserted in RMW_RD of byte store @0x21 → no `dm_we`, mem word unchanged, state IDLE, no `rsp_valid`.
